floatingpoint_to_binary: RTL and testbench
==========================================

# floatingpoint_to_binary

Sequential converter from an IEEE 754 FP32 word to a 32-bit unsigned integer, the inverse of the team's integer-to-FP32 path. It accepts one FP32 word per valid/ready handshake, aligns the significand with an iterative multi-cycle shifter, and truncates toward zero by default. It returns the integer with status flags on a second valid/ready channel, and sits on the datapath wherever FP32 results must be fed back into integer logic.

## Interface
- `SHIFT_PER_CYCLE`, default 1: bits shifted per SHIFT cycle; legal values 1, 2, 4, 8.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `in_valid` input, 1: `in_data` is valid.
- `in_ready` output, 1: converter can accept an input.
- `in_data` input, 32: FP32 operand, laid out {sign, exp[7:0], frac[22:0]}.
- `out_valid` output, 1: result is valid.
- `out_ready` input, 1: consumer takes the result.
- `out_data` output, 32: unsigned integer result.
- `out_flags` output, 4: {nan, ovf, neg, inexact}.

## Operation
- FSM has three states: IDLE, SHIFT and DONE. `in_ready` is 1 only in IDLE; `out_valid` is 1 only in DONE.
- Accept happens when IDLE and `in_valid`. The operand is decoded as s, e and f; sig = {1, f} is held zero-extended in a 32-bit shift register, and guard/sticky are cleared.
- Special-case decode on accept. Each case loads the result directly and goes to DONE with shift count 0; the first matching row wins:
  - e=255, f!=0 gives 0 with nan=1.
  - s=1 with a nonzero value (including -inf) gives 0 with neg=1.
  - +inf, or e>158, gives 0xFFFFFFFF with ovf=1.
  - e=0 (±zero, subnormal) gives 0, with inexact=(f!=0).
  - e<127 (e<126 when rounding is built in) gives 0 with inexact=1.
- Normal path:
  - e>=150: left shift by n=e-150 (0..8). The result is exact.
  - e<150: right shift by n=150-e (1..23, or 24 for e=126 with rounding). Each bit shifted out updates guard/sticky.
- SHIFT state:
  - Each cycle shifts by min(SHIFT_PER_CYCLE, remaining) and decrements the count by the same amount.
  - At remaining=0 the FSM goes to DONE.
  - n=0 on the normal path goes straight to DONE.
- inexact = guard|sticky after the right shift. The result is truncated.
- DONE state:
  - `out_data` and `out_flags` hold stable while `out_valid && !out_ready`.
  - On `out_ready` the FSM returns to IDLE. There is no accept in the same cycle.

## Timing
- On reset: state=IDLE; `in_ready`=0 during the reset cycle and 1 after it; `out_valid`=0, `out_data`=0, `out_flags`=0; the shift register and count are cleared.
- Latency: with accept at edge E0, `out_valid` rises after edge E0+ceil(n/SHIFT_PER_CYCLE). Special cases and n=0 show `out_valid` after E0.
- Throughput: with `out_ready` held high, one conversion every ceil(n/S)+2 cycles.
- `in_ready` falls the cycle after accept. `in_data` is sampled only on the accept edge and may change freely afterwards.
- Reset mid-operation, in SHIFT or DONE: the in-flight conversion is discarded, nothing is emitted, and all outputs take their reset values on the next edge.
- A handshake requires the signal to be high at the rising edge. An `out_ready` that arrives before `out_valid` has no effect.

## Configuration
- `FP2BIN_ROUND_EN` defined:
  - Right-shift results round to nearest, ties to even: increment if guard & (sticky | lsb).
  - The increment is applied on the DONE transition and adds no extra cycle.
  - e=126 takes the shift path (n=24). inexact keeps the meaning "bits discarded".
- `FP2BIN_ROUND_EN` undefined: truncate toward zero.
- The left-shift path and all special cases behave the same either way.

## Test plan
- 0x3F800000 (1.0), S=1: `out_data`=1, flags=0, `out_valid` after edge E0+23. With S=8: after E0+3.
- 0x4F7FFFFF: output 0xFFFFFF00, flags=0, latency 8 at S=1. 0x4F800000 (2^32): output 0xFFFFFFFF, ovf=1, latency 0.
- 0x40600000 (3.5): 3 with inexact=1. With `FP2BIN_ROUND_EN` defined: 4. 0x40200000 (2.5): 2 in both builds.
- Specials:
  - 0x7FC00000 gives 0 with nan=1.
  - 0xBF800000 gives 0 with neg=1.
  - 0x80000000 gives 0 with flags=0.
  - 0x00000001 gives 0 with inexact=1.
  - Each appears after E0.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid`. The output must stay stable and `in_ready` stay 0. After the handshake, `in_ready`=1 on the next cycle.
- Assert `rst` during SHIFT of 0x3F800000: `out_valid` never rises for that operand. A new operand 0x41200000 (10.0) issued after reset returns 10.

Source files
------------

// File: rtl/floatingpoint_to_binary_if.sv
// Handshake bundle for floatingpoint_to_binary: FP32 operand in, unsigned integer and flags out.
interface floatingpoint_to_binary_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface

// File: rtl/floatingpoint_to_binary.sv
// FP32 -> uint32 converter with an iterative significand shifter; flags are {nan, ovf, neg, inexact}.
// Define FP2BIN_ROUND_EN for round-to-nearest-even on the right-shift path (default truncates).
module floatingpoint_to_binary #(
  parameter int unsigned SHIFT_PER_CYCLE = 1
) (
  input logic               clk,
  input logic               rst,
  floatingpoint_to_binary_if.slave bus
);

`ifdef FP2BIN_ROUND_EN
  localparam logic [7:0] EXP_MIN = 8'd126;
`else
  localparam logic [7:0] EXP_MIN = 8'd127;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state, state_n;
  logic [31:0] sr, sr_n;
  logic [4:0]  cnt, cnt_n;
  logic        left, left_n;
  logic        guard, guard_n;
  logic        sticky, sticky_n;
  logic [31:0] data, data_n;
  logic [3:0]  flags, flags_n;

  logic        sgn;
  logic [7:0]  e;
  logic [22:0] f;
  logic [31:0] step;
  logic [31:0] sr_t;
  logic        g_t, s_t;

  always_comb begin
    state_n  = state;
    sr_n     = sr;
    cnt_n    = cnt;
    left_n   = left;
    guard_n  = guard;
    sticky_n = sticky;
    data_n   = data;
    flags_n  = flags;
    sgn      = bus.in_data[31];
    e        = bus.in_data[30:23];
    f        = bus.in_data[22:0];
    step     = '0;
    sr_t     = sr;
    g_t      = guard;
    s_t      = sticky;

    case (state)
      IDLE: begin
        if (bus.in_valid && !rst) begin
          sr_n     = {8'b0, 1'b1, f};
          cnt_n    = '0;
          left_n   = 1'b0;
          guard_n  = 1'b0;
          sticky_n = 1'b0;
          data_n   = '0;
          flags_n  = '0;
          state_n  = DONE;
          // Special rows are priority-ordered; first match wins.
          if (e == 8'hFF && f != '0) begin
            flags_n = 4'b1000;
          end else if (sgn && (e != '0 || f != '0)) begin
            flags_n = 4'b0010;
          end else if (e > 8'd158) begin
            data_n  = '1;
            flags_n = 4'b0100;
          end else if (e == '0) begin
            flags_n = {3'b000, f != '0};
          end else if (e < EXP_MIN) begin
            flags_n = 4'b0001;
          end else if (e >= 8'd150) begin
            left_n = 1'b1;
            cnt_n  = 5'(e - 8'd150);
            if (e == 8'd150) data_n = {8'b0, 1'b1, f};
            else             state_n = SHIFT;
          end else begin
            cnt_n   = 5'(8'd150 - e);
            state_n = SHIFT;
          end
        end
      end

      SHIFT: begin
        step = (32'(cnt) < SHIFT_PER_CYCLE) ? 32'(cnt) : SHIFT_PER_CYCLE;
        for (int unsigned i = 0; i < SHIFT_PER_CYCLE; i++) begin
          if (i < step) begin
            if (left) begin
              sr_t = {sr_t[30:0], 1'b0};
            end else begin
              s_t  = s_t | g_t;
              g_t  = sr_t[0];
              sr_t = {1'b0, sr_t[31:1]};
            end
          end
        end
        sr_n     = sr_t;
        guard_n  = g_t;
        sticky_n = s_t;
        cnt_n    = cnt - 5'(step);
        if (cnt_n == '0) begin
          state_n = DONE;
          flags_n = {3'b000, g_t | s_t};
`ifdef FP2BIN_ROUND_EN
          // Left-shift path never sets guard, so rounding only affects right shifts.
          data_n  = sr_t + {31'b0, g_t & (s_t | sr_t[0])};
`else
          data_n  = sr_t;
`endif
        end
      end

      DONE: begin
        if (bus.out_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sr     <= '0;
      cnt    <= '0;
      left   <= 1'b0;
      guard  <= 1'b0;
      sticky <= 1'b0;
      data   <= '0;
      flags  <= '0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      cnt    <= cnt_n;
      left   <= left_n;
      guard  <= guard_n;
      sticky <= sticky_n;
      data   <= data_n;
      flags  <= flags_n;
    end
  end

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data;
  assign bus.out_flags = flags;

endmodule

// File: tb/tb_floatingpoint_to_binary.sv
// Bench for floatingpoint_to_binary: two instances (1 and 8 bits/cycle) driven in lockstep against an arithmetic model.
module tb_floatingpoint_to_binary;

  localparam int unsigned S_A = 1;
  localparam int unsigned S_B = 8;

`ifdef FP2BIN_ROUND_EN
  localparam int EMIN = 126;
`else
  localparam int EMIN = 127;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  floatingpoint_to_binary_if ifa ();
  floatingpoint_to_binary_if ifb ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_data   = in_data;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_data   = in_data;
  assign ifb.out_ready = out_ready;

  floatingpoint_to_binary #(.SHIFT_PER_CYCLE(S_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  floatingpoint_to_binary #(.SHIFT_PER_CYCLE(S_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Value-level model: significand times a power of two, with quotient/remainder for fractions.
  function automatic void ref_conv(input logic [31:0] x, output logic [31:0] v,
                                   output logic [3:0] fl, output int n);
    longint unsigned m, d, q, r;
    int e;
    logic [22:0] f;
    e  = int'(x[30:23]);
    f  = x[22:0];
    v  = '0;
    fl = '0;
    n  = 0;
    if (e == 255 && f != 0)          fl = 4'b1000;
    else if (x[31] && x[30:0] != 0)  fl = 4'b0010;
    else if (e > 158) begin
      v  = 32'hFFFF_FFFF;
      fl = 4'b0100;
    end
    else if (e == 0)                 fl = (f != 0) ? 4'b0001 : 4'b0000;
    else if (e < EMIN)               fl = 4'b0001;
    else begin
      m = 64'h80_0000 + 64'(f);
      if (e >= 150) begin
        n = e - 150;
        v = 32'(m * (64'd1 << n));
      end else begin
        n = 150 - e;
        d = 64'd1 << n;
        q = m / d;
        r = m % d;
        fl[0] = (r != 0);
`ifdef FP2BIN_ROUND_EN
        if (2 * r > d || (2 * r == d && q[0])) q = q + 1;
`endif
        v = 32'(q);
      end
    end
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    while (!(ifa.in_ready && ifb.in_ready) && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("in_ready_a", 32'(ifa.in_ready), 32'd1);
    check("in_ready_b", 32'(ifb.in_ready), 32'd1);
  endtask

  task automatic run_op(input logic [31:0] x, input bit hold);
    logic [31:0] ev;
    logic [3:0]  ef;
    int n, la, lb;
    ref_conv(x, ev, ef, n);
    wait_ready();
    in_valid = 1'b1;
    in_data  = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom;
    check("busy_a", 32'(ifa.in_ready), 32'd0);
    la = -1;
    lb = -1;
    for (int c = 0; c < 40; c++) begin
      if (la < 0 && ifa.out_valid) la = c;
      if (lb < 0 && ifb.out_valid) lb = c;
      if (la >= 0 && lb >= 0) break;
      @(posedge clk); #1;
    end
    check("lat_a", 32'(la), 32'((n + int'(S_A) - 1) / int'(S_A)));
    check("lat_b", 32'(lb), 32'((n + int'(S_B) - 1) / int'(S_B)));
    check("data_a", ifa.out_data, ev);
    check("flags_a", 32'(ifa.out_flags), 32'(ef));
    check("data_b", ifb.out_data, ev);
    check("flags_b", 32'(ifb.out_flags), 32'(ef));
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clk); #1;
        check("hold_valid_a", 32'(ifa.out_valid), 32'd1);
        check("hold_data_a", ifa.out_data, ev);
        check("hold_flags_a", 32'(ifa.out_flags), 32'(ef));
        check("hold_rdy_a", 32'(ifa.in_ready), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ret_valid_a", 32'(ifa.out_valid), 32'd0);
    check("ret_rdy_a", 32'(ifa.in_ready), 32'd1);
    check("ret_rdy_b", 32'(ifb.in_ready), 32'd1);
  endtask

  task automatic reset_mid_op();
    bit seen;
    wait_ready();
    in_valid = 1'b1;
    in_data  = 32'h3F80_0000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin
      if (ifa.out_valid || ifb.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_rdy", 32'(ifa.in_ready), 32'd0);
    check("rst_valid", 32'(ifa.out_valid | ifb.out_valid), 32'd0);
    check("rst_data_a", ifa.out_data, 32'd0);
    check("rst_flags_a", 32'(ifa.out_flags), 32'd0);
    rst = 1'b0;
    repeat (30) begin
      if (ifa.out_valid || ifb.out_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("no_emit", 32'(seen), 32'd0);
    run_op(32'h4120_0000, 1'b0);
  endtask

  logic [31:0] directed [16] = '{
    32'h3F80_0000, 32'h4F7F_FFFF, 32'h4F80_0000, 32'h4060_0000,
    32'h4020_0000, 32'h7FC0_0000, 32'hBF80_0000, 32'h8000_0000,
    32'h0000_0001, 32'h3F00_0000, 32'h3F40_0000, 32'h4B7F_FFFF,
    32'hFF80_0000, 32'h7F80_0000, 32'h4B00_0001, 32'h3FC0_0000
  };

  initial begin
    logic [31:0] w;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy", 32'(ifa.in_ready), 32'd0);
    check("reset_valid", 32'(ifa.out_valid), 32'd0);
    check("reset_data", ifa.out_data, 32'd0);
    check("reset_flags", 32'(ifa.out_flags), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_reset_rdy", 32'(ifa.in_ready), 32'd1);

    foreach (directed[i]) run_op(directed[i], i == 1);

    reset_mid_op();

    for (int i = 0; i < 40; i++) begin
      w = $urandom;
      if (i % 4 != 0) w[30:23] = 8'($urandom_range(120, 165));
      if (i % 3 != 0) w[31] = 1'b0;
      run_op(w, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
